// File: rtl/microsequencer.sv
// Microcoded instruction sequencer: walks fetch/decode/execute micro-states per opcode with memory stalls and HALT.
// Define MICROSEQ_COND_JUMP_EN to build in the JZ/JC conditional jumps (opcodes 6/7); otherwise they decode as illegal.
module microsequencer #(
  parameter int DATA_W   = 8,
  parameter int OPCODE_W = 4,
  parameter int STATE_W  = 8,
  parameter int CYCLE_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   instruction,
  input  logic                mem_ready,
  input  logic                resume,
  input  logic                flag_z,
  input  logic                flag_c,
  output logic [STATE_W-1:0]  state,
  output logic [CYCLE_W-1:0]  cycle,
  output logic [OPCODE_W-1:0] opcode,
  output logic                halted,
  output logic                instr_done,
  output logic                illegal
);

  localparam logic [STATE_W-1:0] S_FETCH_PC   = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_FETCH_INST = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_NEXT       = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_HALT       = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_ALU_EXEC   = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_ALU_STORE  = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_OPERAND    = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_JUMP       = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_SET_REG    = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_MOV_FETCH  = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_MOV_LOAD   = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_MOV_STORE  = STATE_W'(11);

  localparam logic [OPCODE_W-1:0] OP_NOP = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_ALU = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_MOV = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(7);

  logic [STATE_W-1:0]  r_state;
  logic [CYCLE_W-1:0]  r_cycle;
  logic [OPCODE_W-1:0] r_opcode;
  logic [STATE_W-1:0]  w_next_state;
  logic [CYCLE_W-1:0]  w_next_cycle;
  logic [OPCODE_W-1:0] w_instr_op;
  logic                w_unused;

  function automatic logic op_defined(input logic [OPCODE_W-1:0] op);
`ifdef MICROSEQ_COND_JUMP_EN
    return op <= OP_JC;
`else
    return op <= OP_MOV;
`endif
  endfunction

  function automatic logic [STATE_W-1:0] decode_first(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_NOP:         return S_NEXT;
      OP_HLT:         return S_HALT;
      OP_ALU:         return S_ALU_EXEC;
      OP_JMP, OP_LDI: return S_OPERAND;
      OP_MOV:         return S_MOV_FETCH;
`ifdef MICROSEQ_COND_JUMP_EN
      OP_JZ, OP_JC:   return S_OPERAND;
`endif
      default:        return S_NEXT;
    endcase
  endfunction

  function automatic logic [CYCLE_W-1:0] sat_inc(input logic [CYCLE_W-1:0] v);
    return (&v) ? v : v + CYCLE_W'(1);
  endfunction

  assign w_instr_op = instruction[DATA_W-1 -: OPCODE_W];
  // Low instruction bits carry operand data not used here; flags are dead without conditional jumps.
  assign w_unused   = ^{instruction, flag_z, flag_c};

  // State register, T-step counter and opcode latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_FETCH_PC;
      r_cycle  <= '0;
      r_opcode <= '0;
    end else begin
      r_state <= w_next_state;
      r_cycle <= w_next_cycle;
      if (r_state == S_FETCH_INST && mem_ready)
        r_opcode <= w_instr_op;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH_PC:   w_next_state = S_FETCH_INST;
      S_FETCH_INST: if (mem_ready) w_next_state = decode_first(w_instr_op);
      S_NEXT:       w_next_state = S_FETCH_PC;
      S_HALT:       if (resume) w_next_state = S_NEXT;
      S_ALU_EXEC:   w_next_state = S_ALU_STORE;
      S_ALU_STORE:  w_next_state = S_NEXT;
      S_OPERAND: begin
        if (mem_ready) begin
          case (r_opcode)
            OP_JMP:  w_next_state = S_JUMP;
            OP_LDI:  w_next_state = S_SET_REG;
`ifdef MICROSEQ_COND_JUMP_EN
            OP_JZ:   w_next_state = flag_z ? S_JUMP : S_NEXT;
            OP_JC:   w_next_state = flag_c ? S_JUMP : S_NEXT;
`endif
            default: w_next_state = S_NEXT;
          endcase
        end
      end
      S_JUMP:       w_next_state = S_NEXT;
      S_SET_REG:    w_next_state = S_NEXT;
      S_MOV_FETCH:  w_next_state = S_MOV_LOAD;
      S_MOV_LOAD:   if (mem_ready) w_next_state = S_MOV_STORE;
      S_MOV_STORE:  w_next_state = S_NEXT;
      default:      w_next_state = S_FETCH_PC;
    endcase
  end

  // Stalls and HALT are the only self-loops, so a state change marks an advancing edge.
  always_comb begin
    w_next_cycle = r_cycle;
    if (w_next_state == S_FETCH_PC)
      w_next_cycle = '0;
    else if (w_next_state != r_state)
      w_next_cycle = sat_inc(r_cycle);
  end

  // Output logic
  always_comb begin
    halted     = (r_state == S_HALT);
    instr_done = (r_state == S_NEXT);
    illegal    = (r_state == S_NEXT) && !op_defined(r_opcode);
  end

  assign state  = r_state;
  assign cycle  = r_cycle;
  assign opcode = r_opcode;

endmodule

// File: tb/tb_microsequencer.sv
// Scoreboard bench for microsequencer: per-cycle expected state/cycle/flags queued at drive time, compared after the edge.
module tb_microsequencer;
  localparam int DATA_W   = 8;
  localparam int OPCODE_W = 4;
  localparam int STATE_W  = 8;
  localparam int CYCLE_W  = 8;

  localparam logic [2:0] F0 = 3'b000;
  localparam logic [2:0] FH = 3'b100;
  localparam logic [2:0] FD = 3'b010;
  localparam logic [2:0] FI = 3'b001;

  logic                clk = 1'b0;
  logic                reset;
  logic [DATA_W-1:0]   instruction;
  logic                mem_ready;
  logic                resume;
  logic                flag_z;
  logic                flag_c;
  logic [STATE_W-1:0]  state;
  logic [CYCLE_W-1:0]  cycle;
  logic [OPCODE_W-1:0] opcode;
  logic                halted;
  logic                instr_done;
  logic                illegal;

  always #5 clk = ~clk;

  microsequencer #(
    .DATA_W(DATA_W), .OPCODE_W(OPCODE_W), .STATE_W(STATE_W), .CYCLE_W(CYCLE_W)
  ) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .mem_ready(mem_ready),
    .resume(resume), .flag_z(flag_z), .flag_c(flag_c), .state(state), .cycle(cycle),
    .opcode(opcode), .halted(halted), .instr_done(instr_done), .illegal(illegal)
  );

  typedef struct packed {
    logic [STATE_W-1:0] st;
    logic [CYCLE_W-1:0] cy;
    logic [2:0]         fl;
  } exp_t;

  exp_t  sb[$];
  int    n_checks = 0;
  int    n_errors = 0;
  string cur = "init";
  int    idx = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_now(input string tag, input int est, input int ecy, input logic [2:0] efl);
    check({tag, ".state"}, 32'(state), 32'(est));
    check({tag, ".cycle"}, 32'(cycle), 32'(ecy));
    check({tag, ".flags"}, 32'({halted, instr_done, illegal}), 32'(efl));
  endtask

  task automatic begin_instr(input string name, input logic [DATA_W-1:0] instr);
    cur = name;
    idx = 0;
    instruction = instr;
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then compare after the edge.
  task automatic step(input logic mr, input logic rs, input int est, input int ecy, input logic [2:0] efl);
    exp_t e;
    mem_ready = mr;
    resume    = rs;
    e.st = STATE_W'(est);
    e.cy = CYCLE_W'(ecy);
    e.fl = efl;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check($sformatf("%s[%0d].state", cur, idx), 32'(state), 32'(e.st));
    check($sformatf("%s[%0d].cycle", cur, idx), 32'(cycle), 32'(e.cy));
    check($sformatf("%s[%0d].flags", cur, idx), 32'({halted, instr_done, illegal}), 32'(e.fl));
    idx++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    instruction = '0;
    mem_ready = 1'b0;
    resume = 1'b0;
    flag_z = 1'b0;
    flag_c = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_now("reset", 0, 0, F0);
    check("reset.opcode", 32'(opcode), 32'h0);
    reset = 1'b0;

    // NOP: 0,1,2,0 with instr_done for exactly one cycle
    begin_instr("nop", 8'h03);
    step(1, 0, 1, 1, F0);
    step(1, 0, 2, 2, FD);
    step(1, 0, 0, 0, F0);
    check("nop.opcode", 32'(opcode), 32'h0);

    // MOV with a 3-cycle stall in MOV_LOAD; resume during the stall must not matter
    begin_instr("mov", 8'h5A);
    step(1, 0, 1, 1, F0);
    step(1, 0, 9, 2, F0);
    step(1, 0, 10, 3, F0);
    step(0, 0, 10, 3, F0);
    step(0, 1, 10, 3, F0);
    step(0, 0, 10, 3, F0);
    step(1, 0, 11, 4, F0);
    step(1, 0, 2, 5, FD);
    step(1, 0, 0, 0, F0);
    check("mov.opcode", 32'(opcode), 32'h5);

    // ALU with a stall in FETCH_INST
    begin_instr("alu", 8'h2F);
    step(0, 0, 1, 1, F0);
    step(0, 0, 1, 1, F0);
    step(1, 0, 4, 2, F0);
    step(1, 0, 5, 3, F0);
    step(1, 0, 2, 4, FD);
    step(1, 0, 0, 0, F0);
    check("alu.opcode", 32'(opcode), 32'h2);

    // LDI with a stall in OPERAND
    begin_instr("ldi", 8'h40);
    step(1, 0, 1, 1, F0);
    step(1, 0, 6, 2, F0);
    step(0, 0, 6, 2, F0);
    step(1, 0, 8, 3, F0);
    step(1, 0, 2, 4, FD);
    step(1, 0, 0, 0, F0);

    // JMP
    begin_instr("jmp", 8'h30);
    step(1, 0, 1, 1, F0);
    step(1, 0, 6, 2, F0);
    step(1, 0, 7, 3, F0);
    step(1, 0, 2, 4, FD);
    step(1, 0, 0, 0, F0);

    // HLT: ten cycles in HALT (mem_ready toggling is irrelevant), then resume
    begin_instr("hlt", 8'h10);
    step(1, 0, 1, 1, F0);
    step(1, 0, 3, 2, FH);
    for (int i = 0; i < 10; i++) step(i[0], 0, 3, 2, FH);
    step(0, 1, 2, 3, FD);
    step(1, 0, 0, 0, F0);

    // Conditional jumps (flags set before the instruction starts)
`ifdef MICROSEQ_COND_JUMP_EN
    flag_z = 1'b1; flag_c = 1'b0;
    begin_instr("jz_taken", 8'h60);
    step(1, 0, 1, 1, F0);
    step(1, 0, 6, 2, F0);
    step(1, 0, 7, 3, F0);
    step(1, 0, 2, 4, FD);
    step(1, 0, 0, 0, F0);
    flag_z = 1'b0; flag_c = 1'b1;
    begin_instr("jz_not", 8'h60);
    step(1, 0, 1, 1, F0);
    step(1, 0, 6, 2, F0);
    step(1, 0, 2, 3, FD);
    step(1, 0, 0, 0, F0);
    flag_z = 1'b0; flag_c = 1'b1;
    begin_instr("jc_taken", 8'h70);
    step(1, 0, 1, 1, F0);
    step(1, 0, 6, 2, F0);
    step(1, 0, 7, 3, F0);
    step(1, 0, 2, 4, FD);
    step(1, 0, 0, 0, F0);
`else
    flag_z = 1'b1; flag_c = 1'b1;
    begin_instr("jz_illegal", 8'h60);
    step(1, 0, 1, 1, F0);
    step(1, 0, 2, 2, FD | FI);
    step(1, 0, 0, 0, F0);
    begin_instr("jc_illegal", 8'h70);
    step(1, 0, 1, 1, F0);
    step(1, 0, 2, 2, FD | FI);
    step(1, 0, 0, 0, F0);
`endif
    flag_z = 1'b0; flag_c = 1'b0;

    // Undefined opcode 0xF
    begin_instr("opF", 8'hF5);
    step(1, 0, 1, 1, F0);
    step(1, 0, 2, 2, FD | FI);
    check("opF.opcode", 32'(opcode), 32'hF);
    step(1, 0, 0, 0, F0);

    // Reset in ALU_EXEC takes effect without a clock edge
    begin_instr("rst_alu", 8'h20);
    step(1, 0, 1, 1, F0);
    step(1, 0, 4, 2, F0);
    #1 reset = 1'b1;
    #1;
    check_now("rst_alu.async", 0, 0, F0);
    check("rst_alu.opcode", 32'(opcode), 32'h0);
    @(posedge clk);
    #1;
    check_now("rst_alu.held", 0, 0, F0);
    reset = 1'b0;
    begin_instr("after_rst", 8'h00);
    step(1, 0, 1, 1, F0);
    step(1, 0, 2, 2, FD);
    step(1, 0, 0, 0, F0);
    check("after_rst.opcode", 32'(opcode), 32'h0);

    // Reset while HALTed clears halted and restarts fetch
    begin_instr("rst_hlt", 8'h10);
    step(1, 0, 1, 1, F0);
    step(1, 0, 3, 2, FH);
    #1 reset = 1'b1;
    #1;
    check_now("rst_hlt.async", 0, 0, F0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    begin_instr("after_rst_hlt", 8'h2F);
    step(1, 0, 1, 1, F0);
    step(1, 0, 4, 2, F0);
    step(1, 0, 5, 3, F0);
    step(1, 0, 2, 4, FD);
    step(1, 0, 0, 0, F0);

    if (sb.size() != 0) check("scoreboard.empty", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/microsequencer.md
MICROSEQUENCER -- requirements
Module: microsequencer

Interface
REQ-001 Parameter DATA_W, default 8, instruction width in bits.
REQ-002 Parameter OPCODE_W, default 4, opcode field width; opcode = instruction[DATA_W-1 -: OPCODE_W].
REQ-003 Parameter STATE_W, default 8, state output width; must be at least 4.
REQ-004 Parameter CYCLE_W, default 8, cycle counter width; must be at least 3.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 instruction  input  DATA_W  instruction byte from memory data bus.
REQ-008 mem_ready  input  1  memory read data valid this cycle.
REQ-009 resume  input  1  leave HALT.
REQ-010 flag_z, flag_c  input  1 each  ALU zero/carry flags.
REQ-011 state  output  STATE_W  current micro-state, registered.
REQ-012 cycle  output  CYCLE_W  T-step index within the current instruction, registered.
REQ-013 opcode  output  OPCODE_W  latched opcode of the current instruction.
REQ-014 halted  output  1  high while state is HALT.
REQ-015 instr_done  output  1  one-cycle pulse while state is NEXT.
REQ-016 illegal  output  1  one-cycle pulse in the decode step of an undefined opcode.

Function
REQ-017 State encodings: FETCH_PC=0, FETCH_INST=1, NEXT=2, HALT=3, ALU_EXEC=4, ALU_STORE=5, OPERAND=6, JUMP=7, SET_REG=8, MOV_FETCH=9, MOV_LOAD=10, MOV_STORE=11; all values are zero-extended to STATE_W.
REQ-018 Opcode values: NOP=0, HLT=1, ALU=2, JMP=3, LDI=4, MOV=5, JZ=6, JC=7.
REQ-019 The block advances one state per clock, except for stalls: FETCH_INST, OPERAND and MOV_LOAD each hold while mem_ready=0.
REQ-020 The opcode register loads from instruction on the edge that leaves FETCH_INST with mem_ready=1, and holds otherwise.
REQ-021 The block decodes using the instruction value present in that same edge.
REQ-022 State paths per opcode:
- Common prefix: FETCH_PC -> FETCH_INST -> then by opcode as below.
- NOP: -> NEXT.
- HLT: -> HALT.
- ALU: -> ALU_EXEC -> ALU_STORE -> NEXT.
- JMP: -> OPERAND -> JUMP -> NEXT.
- LDI: -> OPERAND -> SET_REG -> NEXT.
- MOV: -> MOV_FETCH -> MOV_LOAD -> MOV_STORE -> NEXT.
REQ-023 NEXT always transitions to FETCH_PC.
REQ-024 HALT holds until resume=1, then transitions to NEXT; resume has no effect in any other state.
REQ-025 cycle is 0 in FETCH_PC and increments by 1 on every advancing edge; it holds during a stall.
REQ-026 cycle returns to 0 on entry to FETCH_PC.
REQ-027 cycle saturates at 2^CYCLE_W-1 and never wraps.
REQ-028 cycle holds while in HALT.
REQ-029 An undefined opcode follows FETCH_INST -> NEXT, and illegal pulses for the one cycle in NEXT.
REQ-030 When stall and resume conditions coincide, the stall rule takes precedence; they cannot both apply in the same state.

Reset
REQ-031 While reset=1, asynchronously: state=FETCH_PC, cycle=0, opcode=0, halted=0, instr_done=0, illegal=0.
REQ-032 A reset asserted at any point, including mid-instruction, a stall or HALT, abandons that instruction; the first edge after deassertion advances FETCH_PC -> FETCH_INST.

Configuration
REQ-033 Macro MICROSEQ_COND_JUMP_EN compiles conditional jumps in or out.
REQ-034 With MICROSEQ_COND_JUMP_EN defined:
- JZ/JC follow FETCH_INST -> OPERAND.
- The flag (flag_z for JZ, flag_c for JC) is sampled on the edge leaving OPERAND.
- Flag=1 -> JUMP -> NEXT; flag=0 -> NEXT, skipping JUMP.
REQ-035 With MICROSEQ_COND_JUMP_EN undefined, opcodes 6 and 7 are undefined and follow REQ-029; flag_z and flag_c are ignored.

Verification
REQ-036 Reset, then NOP (0x0_) with mem_ready=1 -> states 0,1,2,0; cycle 0,1,2,0; instr_done high exactly one cycle.
REQ-037 MOV (0x5_), mem_ready=0 for 3 cycles in MOV_LOAD -> states 0,1,9,10,10,10,10,11,2; cycle holds at 3 while stalled.
REQ-038 HLT (0x1_) -> state 3 with halted=1 for 10 cycles; pulse resume -> 2 then 0; halted drops on leaving HALT.
REQ-039 With MICROSEQ_COND_JUMP_EN: JZ, flag_z=1 -> path 0,1,6,7,2; JZ, flag_z=0 -> path 0,1,6,2. Without the macro: JZ -> path 0,1,2 with illegal pulsed.
REQ-040 Reset asserted in ALU_EXEC -> outputs immediately take reset values with no clock edge; after deassertion, the FETCH_PC sequence restarts with opcode=0.
REQ-041 Opcode 0xF -> path 0,1,2 with illegal=1 in NEXT only; opcode output reads 0xF.
